mem_arbiter: RTL and testbench

- Shares the single four-bank main memory between the instruction-cache controller (requester 0) and the data-cache controller (requester 1).
- Grants at most one memory command per cycle, using round-robin priority.
- Supports a lock so one cache controller can own memory for a multi-beat line writeback or fill.
- Routes each read return, and any error, back to the requester that issued it.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main memory port between the instruction-cache
// controller (requester 0) and the data-cache controller (requester 1).
// Round-robin grant, optional lock for multi-beat bursts, and a tag
// pipeline that routes each read return back to the requester that issued it.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2     // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_rd,
    input  logic [1:0]        req_wr,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ptr;          // requester favoured when both are active
    logic [RD_LAT-1:0] r_pv;           // return pipeline valid bits, [RD_LAT-1] is the head
    logic [RD_LAT-1:0] r_pid;          // return pipeline requester ids
    logic [1:0]        r_err;

    logic [1:0]        w_act;
    logic              w_cand;
    logic              w_cand_vld;
    logic              w_grant;
    logic              w_cand_rd;
    logic              w_cand_wr;
    logic              w_cand_lock;
    logic              w_both;
    logic              w_head_vld;
    logic              w_head_id;

    // Candidate selection: pointer breaks ties in IDLE, owner is the only candidate when locked
    always_comb begin
        w_act      = req_rd | req_wr;
        w_cand     = 1'b0;
        w_cand_vld = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (&w_act) begin
                    w_cand = r_ptr;
                end else begin
                    w_cand = w_act[1];
                end
                w_cand_vld = |w_act;
            end
            ST_OWN0: begin
                w_cand     = 1'b0;
                w_cand_vld = w_act[0];
            end
            ST_OWN1: begin
                w_cand     = 1'b1;
                w_cand_vld = w_act[1];
            end
            default: begin
                w_cand     = 1'b0;
                w_cand_vld = 1'b0;
            end
        endcase
        w_cand_rd   = req_rd[w_cand];
        w_cand_wr   = req_wr[w_cand];
        w_cand_lock = req_lock[w_cand];
        w_both      = w_cand_rd & w_cand_wr;
        // Reset gating keeps every command output quiet while rst is held
        w_grant     = w_cand_vld & ~mem_stall & ~rst;
    end

    // Next-state logic; a stall never blocks the release of a lock
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant && w_cand_lock) begin
                    w_state_nxt = w_cand ? ST_OWN1 : ST_OWN0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!req_lock[0]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!req_lock[1]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OWN1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin pointer: after any grant the other requester is favoured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= ~w_cand;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Return tag pipeline: shifts every cycle, stalls do not hold it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv  <= '0;
            r_pid <= '0;
        end else begin
            r_pv[0]  <= w_grant & w_cand_rd;
            r_pid[0] <= w_cand;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k]  <= r_pv[k-1];
                r_pid[k] <= r_pid[k-1];
            end
        end
    end

    // Error pulse: memory-flagged or rd+wr conflict on a granted beat, one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 2'b00;
        end else if (w_grant && (mem_err || w_both)) begin
            r_err <= w_cand ? 2'b10 : 2'b01;
        end else begin
            r_err <= 2'b00;
        end
    end

    // Output mux: memory command follows the granted candidate, read wins over write
    always_comb begin
        w_head_vld = r_pv[RD_LAT-1];
        w_head_id  = r_pid[RD_LAT-1];
        gnt        = 2'b00;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = {ADDR_W{1'b0}};
        mem_wdata  = {DATA_W{1'b0}};
        if (w_grant) begin
            gnt       = w_cand ? 2'b10 : 2'b01;
            mem_rd    = w_cand_rd;
            mem_wr    = w_cand_wr & ~w_cand_rd;
            mem_addr  = w_cand ? req_addr1 : req_addr0;
            mem_wdata = w_cand ? req_wdata1 : req_wdata0;
        end else begin
            gnt       = 2'b00;
        end
        if (w_head_vld) begin
            rvalid = w_head_id ? 2'b10 : 2'b01;
            rdata  = mem_rdata;
        end else begin
            rvalid = 2'b00;
            rdata  = {DATA_W{1'b0}};
        end
        err = r_err;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized traffic plus directed scenarios,
// every cycle compared against a cycle-indexed reference model.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_rd, req_wr, req_lock;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic [DATA_W-1:0] req_wdata0, req_wdata1;
    logic [1:0]        gnt, rvalid, err;
    logic [DATA_W-1:0] rdata;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_stall;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: owner (-1 = nobody), favoured requester,
    // pending error pulse, and returns scheduled by absolute cycle number.
    int         m_owner = -1;
    int         m_ptr   = 0;
    logic [1:0] m_err_pend = 2'b00;
    int         ret_slot[8];
    bit         m_g;
    int         m_c;

    // Random requester records (held until granted)
    bit              p_pend[2];
    bit              p_rd[2], p_wr[2], p_lock[2];
    logic [ADDR_W-1:0] p_addr[2];
    logic [DATA_W-1:0] p_data[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: evaluate at negedge against the model, then advance past posedge.
    // sel bits request extra directed checks: [0] gnt, [1] rvalid, [2] err.
    task automatic step(input logic [2:0] sel, input logic [1:0] x_gnt,
                        input logic [1:0] x_rv, input logic [1:0] x_err);
        logic [1:0] e_gnt, e_rv, e_err;
        logic       e_rd, e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data, e_rdata;
        bit a0, a1, v;
        int c, slot;
        mem_rdata = DATA_W'($urandom);
        @(negedge clk);
        e_gnt = 2'b00; e_rv = 2'b00; e_err = 2'b00; e_rd = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_data = '0; e_rdata = '0;
        m_g = 1'b0; m_c = 0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_err_pend = 2'b00;
            for (int k = 0; k < 8; k++) ret_slot[k] = 0;
        end else begin
            a0 = req_rd[0] | req_wr[0];
            a1 = req_rd[1] | req_wr[1];
            if (m_owner < 0) begin
                c = (a0 && a1) ? m_ptr : (a1 ? 1 : 0);
                v = a0 | a1;
            end else begin
                c = m_owner;
                v = (c == 1) ? a1 : a0;
            end
            m_g = v && !mem_stall;
            m_c = c;
            if (m_g) begin
                e_gnt  = (c == 1) ? 2'b10 : 2'b01;
                e_rd   = req_rd[c];
                e_wr   = req_wr[c] && !req_rd[c];
                e_addr = (c == 1) ? req_addr1 : req_addr0;
                e_data = (c == 1) ? req_wdata1 : req_wdata0;
            end
            slot = ret_slot[cyc % 8];
            ret_slot[cyc % 8] = 0;
            if (slot != 0) begin
                e_rv    = (slot == 2) ? 2'b10 : 2'b01;
                e_rdata = mem_rdata;
            end
            e_err = m_err_pend;
            m_err_pend = (m_g && (mem_err || (req_rd[c] && req_wr[c])))
                         ? ((c == 1) ? 2'b10 : 2'b01) : 2'b00;
            if (m_g && req_rd[c]) ret_slot[(cyc + RD_LAT) % 8] = c + 1;
            if (m_g) m_ptr = 1 - c;
            if (m_owner < 0) begin
                if (m_g && req_lock[c]) m_owner = c;
            end else if (!req_lock[m_owner]) begin
                m_owner = -1;
            end
        end
        chk("gnt",       32'(gnt),       32'(e_gnt));
        chk("rvalid",    32'(rvalid),    32'(e_rv));
        chk("rdata",     32'(rdata),     32'(e_rdata));
        chk("err",       32'(err),       32'(e_err));
        chk("mem_rd",    32'(mem_rd),    32'(e_rd));
        chk("mem_wr",    32'(mem_wr),    32'(e_wr));
        chk("mem_addr",  32'(mem_addr),  32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_data));
        if (sel[0]) chk("dir_gnt", 32'(gnt),    32'(x_gnt));
        if (sel[1]) chk("dir_rv",  32'(rvalid), 32'(x_rv));
        if (sel[2]) chk("dir_err", 32'(err),    32'(x_err));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        req_rd = 2'b00; req_wr = 2'b00; req_lock = 2'b00;
        mem_stall = 1'b0; mem_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        mem_rdata = '0;
        for (int k = 0; k < 8; k++) ret_slot[k] = 0;
        for (int i = 0; i < 2; i++) p_pend[i] = 1'b0;

        // Reset state: requests present but everything must stay quiet
        req_rd = 2'b11;
        step(3'b111, 2'b00, 2'b00, 2'b00);
        step(3'b111, 2'b00, 2'b00, 2'b00);
        req_rd = 2'b00;
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom % 300) == 0;
            for (int i = 0; i < 2; i++) begin
                if (!p_pend[i] && ($urandom % 100) < 60) begin
                    int kind;
                    kind = $urandom % 10;
                    p_pend[i] = 1'b1;
                    p_rd[i]   = (kind < 5);
                    p_wr[i]   = (kind == 0) || (kind >= 5);
                    p_lock[i] = ($urandom % 4) == 0;
                    p_addr[i] = ADDR_W'($urandom);
                    p_data[i] = DATA_W'($urandom);
                end
                req_rd[i]   = p_pend[i] & p_rd[i];
                req_wr[i]   = p_pend[i] & p_wr[i];
                req_lock[i] = p_pend[i] ? p_lock[i] : 1'($urandom % 2);
            end
            req_addr0 = p_addr[0]; req_wdata0 = p_data[0];
            req_addr1 = p_addr[1]; req_wdata1 = p_data[1];
            mem_stall = ($urandom % 5) == 0;
            mem_err   = ($urandom % 10) == 0;
            step(3'b000, 2'b00, 2'b00, 2'b00);
            if (m_g) p_pend[m_c] = 1'b0;
        end

        // Known starting point for the directed scenarios
        idle_inputs();
        rst = 1'b1;
        step(3'b000, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        step(3'b000, 2'b00, 2'b00, 2'b00);
        step(3'b000, 2'b00, 2'b00, 2'b00);

        // Stall for 3 cycles while requester 1 holds a write to 0x0040
        req_wr = 2'b10; req_addr1 = 16'h0040; req_wdata1 = 16'hBEEF; mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) step(3'b001, 2'b00, 2'b00, 2'b00);
        mem_stall = 1'b0;
        step(3'b001, 2'b10, 2'b00, 2'b00);
        chk("stall_addr_seen", 32'(req_addr1), 32'h0040);
        idle_inputs();

        // rd and wr together from requester 0 at 0x0010 (pointer now at 0)
        req_rd = 2'b01; req_wr = 2'b01; req_addr0 = 16'h0010;
        step(3'b001, 2'b01, 2'b00, 2'b00);
        idle_inputs();
        step(3'b100, 2'b00, 2'b00, 2'b01);
        step(3'b011, 2'b00, 2'b01, 2'b00);

        // mem_err on a granted read by requester 1
        req_rd = 2'b10; req_addr1 = 16'h1234; mem_err = 1'b1;
        step(3'b001, 2'b10, 2'b00, 2'b00);
        idle_inputs();
        step(3'b100, 2'b00, 2'b00, 2'b10);
        step(3'b010, 2'b00, 2'b10, 2'b00);

        // Single read by requester 0 so the pointer favours requester 1
        req_rd = 2'b01; req_addr0 = 16'h0020;
        step(3'b001, 2'b01, 2'b00, 2'b00);
        idle_inputs();
        step(3'b000, 2'b00, 2'b00, 2'b00);
        step(3'b000, 2'b00, 2'b00, 2'b00);

        // 4-beat locked write burst by requester 1, requester 0 reading throughout
        req_rd = 2'b01; req_addr0 = 16'h0300;
        for (int b = 0; b < 4; b++) begin
            req_wr = 2'b10;
            req_lock = (b < 3) ? 2'b10 : 2'b00;
            req_addr1 = 16'h0400 + 16'(b);
            req_wdata1 = DATA_W'($urandom);
            step(3'b001, 2'b10, 2'b00, 2'b00);
        end
        req_wr = 2'b00; req_lock = 2'b00;
        step(3'b001, 2'b01, 2'b00, 2'b00);
        idle_inputs();
        for (int k = 0; k < RD_LAT; k++) step(3'b000, 2'b00, 2'b00, 2'b00);

        // Reset one cycle after two reads are granted
        req_rd = 2'b11;
        step(3'b000, 2'b00, 2'b00, 2'b00);
        step(3'b000, 2'b00, 2'b00, 2'b00);
        req_rd = 2'b00;
        rst = 1'b1;
        step(3'b011, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        req_rd = 2'b11;
        step(3'b011, 2'b01, 2'b00, 2'b00);
        idle_inputs();
        for (int k = 0; k < RD_LAT + 1; k++) step(3'b000, 2'b00, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
